// File: rtl/seg_scan_ctrl.sv
// Multiplexed hex display scanner: one shared decoder, NUM_DIGITS common-anode digits,
// inter-digit blanking, leading-zero suppression and frame-aligned value updates.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 50000,
  parameter int BLANK      = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [3:0]              hex_out,
  output logic                    seg_blank,
  output logic [NUM_DIGITS-1:0]   dig_an,
  output logic                    load_ack,
  output logic                    frame_done
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DW_LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL_LAST  = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic {S_DRIVE, S_BLANK} state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0]     shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][3:0]     pend_q, pend_d;
  logic                           pend_v_q, pend_v_d;
  logic [NUM_DIGITS-1:0]          an_q, an_d;
  logic [3:0]                     hex_q, hex_d;
  logic                           blank_q, blank_d;
  logic                           ack_q, ack_d;
  logic                           fd_q, fd_d;
  logic                           adv, boundary, sup;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + CW'(1);
    shadow_d = shadow_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    adv      = 1'b0;
    boundary = 1'b0;

    case (state_q)
      S_DRIVE: begin
        if (cnt_q == DW_LAST) begin
          cnt_d = '0;
          if (BLANK == 0) adv = 1'b1;
          else            state_d = S_BLANK;
        end
      end
      S_BLANK: begin
        if (cnt_q == BL_LAST) begin
          cnt_d = '0;
          adv   = 1'b1;
        end
      end
      default: begin
        state_d = S_DRIVE;
        cnt_d   = '0;
      end
    endcase

    if (adv) begin
      state_d = S_DRIVE;
      if (idx_q == IDX_LAST) begin
        idx_d    = '0;
        boundary = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    // Commit uses the old pending value, so a load in the commit cycle waits a frame.
    if (boundary && pend_v_q) begin
      shadow_d = pend_q;
      pend_v_d = 1'b0;
    end
    if (load) begin
      pend_d   = value_in;
      pend_v_d = 1'b1;
    end

    sup = lz_en && (idx_d != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_d) && shadow_d[i] != 4'h0) sup = 1'b0;
    end

    // Outputs are registered from the next state so they line up with state_q.
    an_d    = '1;
    hex_d   = hex_q;
    blank_d = 1'b1;
    if (state_d == S_DRIVE) begin
      an_d[idx_d] = 1'b0;
      hex_d       = shadow_d[idx_d];
      blank_d     = sup;
    end
    ack_d = boundary && pend_v_q;
    fd_d  = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_DRIVE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      an_q     <= AN_RST;
      hex_q    <= 4'h0;
      blank_q  <= 1'b0;
      ack_q    <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      an_q     <= an_d;
      hex_q    <= hex_d;
      blank_q  <= blank_d;
      ack_q    <= ack_d;
      fd_q     <= fd_d;
    end
  end

  assign dig_an     = an_q;
  assign hex_out    = hex_q;
  assign seg_blank  = blank_q;
  assign load_ack   = ack_q;
  assign frame_done = fd_q;

endmodule
